imem_responder: RTL
===================

Name: imem_responder

Overview:
- Responder end of the fetch stage's instruction-memory request interface.
- Accepts word read requests on Addr/Rd and answers with DataOut/Done/Stall/CacheHit/err.
- Backs a direct-mapped, read-only instruction cache with a 4-word-line refill engine that reads a multi-cycle backing memory.
- Sits between the fetch stage and the backing memory port.

Parameters:
LINES  8  number of cache lines; power of two, 2..64; index width IW = log2(LINES)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
Addr  in  16  byte address of requested instruction word
Rd  in  1  read request, level-sensitive
Wr  in  1  write request; unsupported, flagged as error
DataIn  in  16  write data; unused
createdump  in  1  halt/dump indication; no functional effect
DataOut  out  16  requested instruction word, valid when Done=1
Done  out  1  response valid this cycle
Stall  out  1  responder busy or refilling
CacheHit  out  1  with Done: 1 = served from cache, 0 = served after refill
err  out  1  error response, valid with Done
mem_addr  out  16  backing-memory word address
mem_rd  out  1  backing-memory read request
mem_rdata  in  16  backing-memory read data
mem_valid  in  1  mem_rdata valid, accepted only while mem_rd=1

Behaviour:
- Address split:
  - Addr[0] = byte bit, must be 0.
  - Addr[2:1] = word offset.
  - Addr[3+IW-1:3] = index.
  - Addr[15:3+IW] = tag.
- Storage: per line, one valid bit, one tag, and four 16-bit words.
- States: IDLE, FILL, RESP.
- Reset (rst=0, async):
  - State goes to IDLE and all valid bits clear.
  - DataOut, Done, Stall, CacheHit, err, mem_rd and mem_addr all go to 0.
  - Reset mid-FILL abandons the refill; the line stays invalid.
- IDLE, Rd=0: all outputs 0.
- IDLE, error case (Rd=1 and (Wr=1 or Addr[0]=1)), same cycle:
  - Done=1, err=1, CacheHit=0, Stall=0, DataOut=0.
  - No state change, no refill.
- IDLE, Wr=1 with Rd=0: Done=1, err=1, same cycle.
- IDLE hit (Rd=1, legal, valid and tag match), combinational, zero latency:
  - Done=1, CacheHit=1, Stall=0.
  - DataOut = word[offset].
- IDLE miss (Rd=1, legal, no hit), same cycle:
  - Done=0, Stall=1.
  - Latch Addr into req_addr.
  - Next state FILL with word counter = 0.
- FILL:
  - Outputs: Stall=1, Done=0, mem_rd=1, mem_addr = {req_addr[15:3], cnt[1:0], 1'b0}.
  - On mem_valid=1: write mem_rdata into word[cnt] of the line; cnt increments.
  - mem_addr and mem_rd stay stable until mem_valid arrives; no timeout.
  - mem_valid may arrive in the same cycle mem_rd first rises (zero-latency memory is legal).
  - After the 4th accepted word: set the line's valid bit and tag, go to RESP.
- RESP (one cycle):
  - Done=1, CacheHit=0, Stall=0, mem_rd=0.
  - DataOut = word[req_addr offset].
  - Next state IDLE.
- Miss latency: Done rises the cycle after the 4th mem_valid.
- Addr/Rd changes during FILL/RESP are ignored. The response always refers to req_addr; the requester re-presents the address if it changed.
- Refills go through the single line per index, replacing any previous tag (conflict eviction).
- Rd is not required to drop between requests; back-to-back hits return one word per cycle.
- No writes ever reach the backing memory.

Test Plan:
- Reset: hold rst=0 with Rd=1 and Addr=0x0000 -> Done=0, Stall=0, mem_rd=0. Release -> first read misses.
- Cold miss: Addr=0x0014, memory returns word address×3 with 2-cycle latency:
  - mem_addr sequence is 0x0010, 0x0012, 0x0014, 0x0016.
  - Done=1, CacheHit=0 and DataOut=0x003C one cycle after the 4th mem_valid.
- Hits: after the refill, Addr=0x0010, 0x0012, 0x0016 on consecutive cycles -> Done=1 and CacheHit=1 each cycle, DataOut=0x0030, 0x0036, 0x0042, mem_rd stays 0.
- Conflict: LINES=8, read 0x0010 then 0x0050 (same index, different tag) -> second access refills. A subsequent 0x0010 misses again.
- Error: Rd=1 with Addr=0x0011 -> Done=1, err=1 same cycle, no mem_rd. Rd=1 with Wr=1 -> same response.
- Reset mid-fill: assert rst=0 after the 2nd mem_valid of a miss on 0x0020, then release and read 0x0020 -> full 4-word refill repeats, starting at mem_addr=0x0020.

Source files
------------

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory responder with direct-mapped read-only cache and 4-word refill
module imem_responder #(
    parameter int LINES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [15:0] DataIn,
    input  logic        createdump,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid
);

    localparam int IW = $clog2(LINES);
    localparam int TW = 13 - IW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [15:0]      req_addr_q, req_addr_d;
    logic [LINES-1:0] valid_q, valid_d;

    logic [TW-1:0]    tag_q  [LINES];
    logic [15:0]      data_q [LINES][4];

    logic [IW-1:0]    idx_in, req_idx;
    logic [TW-1:0]    tag_in;
    logic [1:0]       off_in, req_off;
    logic             bad_req, hit, miss, fill_accept, fill_last;

    logic             unused_ok;
    assign unused_ok = ^{DataIn, createdump, req_addr_q[0]};

    assign idx_in  = Addr[3 +: IW];
    assign tag_in  = Addr[15 -: TW];
    assign off_in  = Addr[2:1];
    assign req_idx = req_addr_q[3 +: IW];
    assign req_off = req_addr_q[2:1];

    // A write, with or without Rd, or a misaligned read is refused outright.
    assign bad_req     = Wr | (Rd & Addr[0]);
    assign hit         = Rd & ~bad_req & valid_q[idx_in] & (tag_q[idx_in] == tag_in);
    assign miss        = Rd & ~bad_req & ~hit;
    assign fill_accept = (state_q == S_FILL) & mem_valid;
    assign fill_last   = fill_accept & (cnt_q == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            req_addr_q <= 16'h0000;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_addr_q <= req_addr_d;
            valid_q    <= valid_d;
        end
    end

    // Line payload and tags need no reset: the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_accept) begin
            data_q[req_idx][cnt_q] <= mem_rdata;
        end
        if (fill_last) begin
            tag_q[req_idx] <= req_addr_q[15 -: TW];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_addr_d = req_addr_q;
        valid_d    = valid_q;
        case (state_q)
            S_IDLE: begin
                if (miss) begin
                    req_addr_d      = Addr;
                    cnt_d           = 2'd0;
                    valid_d[idx_in] = 1'b0;
                    state_d         = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_valid) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        valid_d[req_idx] = 1'b1;
                        state_d          = S_RESP;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are forced low while reset is held, even with a request pending.
    always_comb begin
        DataOut  = 16'h0000;
        Done     = 1'b0;
        Stall    = 1'b0;
        CacheHit = 1'b0;
        err      = 1'b0;
        mem_addr = 16'h0000;
        mem_rd   = 1'b0;
        if (rst) begin
            case (state_q)
                S_IDLE: begin
                    if (bad_req) begin
                        Done = 1'b1;
                        err  = 1'b1;
                    end else if (hit) begin
                        Done     = 1'b1;
                        CacheHit = 1'b1;
                        DataOut  = data_q[idx_in][off_in];
                    end else if (miss) begin
                        Stall = 1'b1;
                    end
                end
                S_FILL: begin
                    Stall    = 1'b1;
                    mem_rd   = 1'b1;
                    mem_addr = {req_addr_q[15:3], cnt_q, 1'b0};
                end
                S_RESP: begin
                    Done    = 1'b1;
                    DataOut = data_q[req_idx][req_off];
                end
                default: begin
                    DataOut = 16'h0000;
                end
            endcase
        end
    end

endmodule
